hop_afh_remap_seq: RTL and testbench

- Sequential AFH channel-remapping engine for the hop-selection path; parametrised in channel count and scan width. Covers Classic (NCH=79) and reduced-channel modes (e.g. NCH=40).
- The hop kernel supplies an unmapped channel fk_in and a remap index (F' mod N). The engine resolves the index against the active channel map by scanning the map SCAN_W channels per cycle.
- It adds start/done handshaking, a double-buffered channel map, used-channel counting and error flagging.

---
 rtl/hop_afh_remap_seq_if.sv | 30 +++
 rtl/hop_afh_remap_seq.sv | 172 +++++++++++++++++
 tb/tb_hop_afh_remap_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hop_afh_remap_seq_if.sv
// Request/response and channel-map bundle for the AFH remap engine.
// The master side issues hop requests and map updates; the slave side is the engine.
interface hop_afh_remap_seq_if #(
  parameter int NCH = 79,
  parameter int CHW = 7
);
  logic           start_p;
  logic           abort_p;
  logic [CHW-1:0] fk_in;
  logic [CHW-1:0] remap_idx;
  logic           afh_en;
  logic [NCH-1:0] chmap;
  logic           map_upd_p;
  logic           busy;
  logic           done_p;
  logic [CHW-1:0] fk_out;
  logic           remapped;
  logic           err;
  logic [CHW-1:0] used_n;

  modport master (
    output start_p, abort_p, fk_in, remap_idx, afh_en, chmap, map_upd_p,
    input  busy, done_p, fk_out, remapped, err, used_n
  );

  modport slave (
    input  start_p, abort_p, fk_in, remap_idx, afh_en, chmap, map_upd_p,
    output busy, done_p, fk_out, remapped, err, used_n
  );
endinterface

// File: rtl/hop_afh_remap_seq.sv
// AFH channel remapping: resolves an unmapped hop channel against a double-buffered
// channel map, scanning SCAN_W channels per cycle to find the (idx+1)-th used channel.
//
// state | meaning
// IDLE  | waiting for start_p; pending map may be promoted to the active map
// CHECK | range check, direct-hit check, remap index validity check
// SCAN  | walk the active map SCAN_W channels per cycle counting used channels
// DONE  | one-cycle done_p strobe, results already registered
module hop_afh_remap_seq #(
  parameter int NCH    = 79,
  parameter int CHW    = 7,
  parameter int SCAN_W = 1
) (
  input  logic             clk_6M,
  input  logic             rstz,
  hop_afh_remap_seq_if.slave bus
);

  localparam int MAPX = (1 << CHW) + SCAN_W;

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [NCH-1:0]    act_map, pend_map;
  logic              pend_vld, xfer;
  logic [CHW-1:0]    fk_l, idx_l, cnt, base, used_n_r, pop_act;
  logic              afh_en_l;
  logic [CHW-1:0]    fk_out_r;
  logic              remapped_r, err_r;
  logic [MAPX-1:0]   map_ext;
  logic [SCAN_W-1:0] grp;
  logic              map_bit, chk_bad, chk_direct, chk_noidx;
  logic              hit, scan_end;
  logic [CHW-1:0]    hit_ch, run;

  // Zero-extended map so out-of-range channels read as unused.
  assign map_ext    = MAPX'(act_map);
  assign map_bit    = |(map_ext & (MAPX'(1) << fk_l));
  assign chk_bad    = {1'b0, fk_l} >= (CHW+1)'(NCH);
  assign chk_direct = !afh_en_l || map_bit;
  assign chk_noidx  = (used_n_r == '0) || (idx_l >= used_n_r);
  assign scan_end   = ({1'b0, base} + (CHW+1)'(SCAN_W)) >= (CHW+1)'(NCH);
  assign xfer       = (state == IDLE) && pend_vld && !bus.start_p;

  always_comb begin
    for (int k = 0; k < SCAN_W; k++)
      grp[k] = |(map_ext & (MAPX'(1) << (base + CHW'(k))));
  end

  // run is the used-channel count before each group member; hit when it equals idx.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    run    = cnt;
    for (int k = 0; k < SCAN_W; k++) begin
      if (grp[k] && !hit) begin
        if (run == idx_l) begin
          hit    = 1'b1;
          hit_ch = base + CHW'(k);
        end
        run = run + CHW'(1);
      end
    end
  end

  always_comb begin
    pop_act = '0;
    for (int i = 0; i < NCH; i++)
      pop_act = pop_act + CHW'(act_map[i]);
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort_p) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_p) state_nxt = CHECK;
        CHECK:   state_nxt = (chk_bad || chk_direct || chk_noidx) ? DONE : SCAN;
        SCAN:    if (hit || scan_end) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done_p = (state == DONE) && !bus.abort_p;
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      act_map  <= '1;
      pend_map <= '0;
      pend_vld <= 1'b0;
      used_n_r <= CHW'(NCH);
    end else begin
      used_n_r <= pop_act;
      if (xfer) act_map <= pend_map;
      if (bus.map_upd_p) begin
        pend_map <= bus.chmap;
        pend_vld <= 1'b1;
      end else if (xfer) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      fk_l       <= '0;
      idx_l      <= '0;
      afh_en_l   <= 1'b0;
      cnt        <= '0;
      base       <= '0;
      fk_out_r   <= '0;
      remapped_r <= 1'b0;
      err_r      <= 1'b0;
    end else if (!bus.abort_p) begin
      case (state)
        IDLE: begin
          if (bus.start_p) begin
            fk_l     <= bus.fk_in;
            idx_l    <= bus.remap_idx;
            afh_en_l <= bus.afh_en;
          end
        end
        CHECK: begin
          if (chk_bad || (!chk_direct && chk_noidx)) begin
            fk_out_r   <= fk_l;
            remapped_r <= 1'b0;
            err_r      <= 1'b1;
          end else if (chk_direct) begin
            fk_out_r   <= fk_l;
            remapped_r <= 1'b0;
            err_r      <= 1'b0;
          end else begin
            base <= '0;
            cnt  <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            fk_out_r   <= hit_ch;
            remapped_r <= 1'b1;
            err_r      <= 1'b0;
          end else if (scan_end) begin
            fk_out_r   <= fk_l;
            remapped_r <= 1'b0;
            err_r      <= 1'b1;
          end else begin
            cnt  <= run;
            base <= base + CHW'(SCAN_W);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fk_out   = fk_out_r;
  assign bus.remapped = remapped_r;
  assign bus.err      = err_r;
  assign bus.used_n   = used_n_r;

endmodule

// File: tb/tb_hop_afh_remap_seq.sv
// Bench for hop_afh_remap_seq: SCAN_W=1 and SCAN_W=4 engines driven in lockstep,
// checked against a used-channel-list reference model.
module tb_hop_afh_remap_seq;
  localparam int NCH = 79;
  localparam int CHW = 7;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  hop_afh_remap_seq_if #(.NCH(NCH), .CHW(CHW)) b1 ();
  hop_afh_remap_seq_if #(.NCH(NCH), .CHW(CHW)) b4 ();

  assign b4.start_p   = b1.start_p;
  assign b4.abort_p   = b1.abort_p;
  assign b4.fk_in     = b1.fk_in;
  assign b4.remap_idx = b1.remap_idx;
  assign b4.afh_en    = b1.afh_en;
  assign b4.chmap     = b1.chmap;
  assign b4.map_upd_p = b1.map_upd_p;

  hop_afh_remap_seq #(.NCH(NCH), .CHW(CHW), .SCAN_W(1)) dut1 (.clk_6M(clk), .rstz(rstz), .bus(b1));
  hop_afh_remap_seq #(.NCH(NCH), .CHW(CHW), .SCAN_W(4)) dut4 (.clk_6M(clk), .rstz(rstz), .bus(b4));

  int total = 0;
  int bad = 0;
  bit [NCH-1:0] m_act;
  int h_fk = 0, h_rm = 0, h_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: list used channels in order and pick by index.
  task automatic model_req(input int fk, input int idx, input int en,
                           output int efk, output int erm, output int eerr, output int ech);
    int used[$];
    for (int i = 0; i < NCH; i++) if (m_act[i]) used.push_back(i);
    efk = fk; erm = 0; eerr = 0; ech = -1;
    if (fk >= NCH) eerr = 1;
    else if (en == 0 || m_act[fk]) eerr = 0;
    else if (idx >= used.size()) eerr = 1;
    else begin
      ech = used[idx];
      efk = ech;
      erm = 1;
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int efk, input int erm,
                                    input int eerr, input int eused);
    chk({tag, "_busy1"}, int'(b1.busy), 0);
    chk({tag, "_busy4"}, int'(b4.busy), 0);
    chk({tag, "_done1"}, int'(b1.done_p), 0);
    chk({tag, "_done4"}, int'(b4.done_p), 0);
    chk({tag, "_fk1"}, int'(b1.fk_out), efk);
    chk({tag, "_fk4"}, int'(b4.fk_out), efk);
    chk({tag, "_rm1"}, int'(b1.remapped), erm);
    chk({tag, "_rm4"}, int'(b4.remapped), erm);
    chk({tag, "_err1"}, int'(b1.err), eerr);
    chk({tag, "_err4"}, int'(b4.err), eerr);
    chk({tag, "_used1"}, int'(b1.used_n), eused);
    chk({tag, "_used4"}, int'(b4.used_n), eused);
  endtask

  task automatic load_map(input string tag, input bit [NCH-1:0] m);
    @(posedge clk); #1;
    b1.chmap = m;
    b1.map_upd_p = 1'b1;
    @(posedge clk); #1;
    b1.map_upd_p = 1'b0;
    repeat (3) @(posedge clk);
    m_act = m;
    @(negedge clk);
    chk({tag, "_used1"}, int'(b1.used_n), $countones(m));
    chk({tag, "_used4"}, int'(b4.used_n), $countones(m));
  endtask

  // Called just after a negedge; start_p is sampled at the next posedge (cycle t).
  task automatic run_req(input string tag, input int fk, input int idx, input int en,
                         input int upd_at, input bit [NCH-1:0] upd_map,
                         input int st2_at, input int abort_at);
    int efk, erm, eerr, ech, el1, el4;
    int lat1, lat4, n1, n4, lat, mx;
    int used_exp;
    model_req(fk, idx, en, efk, erm, eerr, ech);
    el1 = (ech < 0) ? 2 : 3 + ech;
    el4 = (ech < 0) ? 2 : 3 + ech / 4;
    used_exp = $countones(m_act);
    lat1 = -1; lat4 = -1; n1 = 0; n4 = 0; lat = 0;
    b1.fk_in = CHW'(fk);
    b1.remap_idx = CHW'(idx);
    b1.afh_en = (en != 0);
    b1.start_p = 1'b1;
    while (lat < 150) begin
      @(posedge clk);
      lat++;
      #1;
      b1.start_p = (lat == st2_at);
      if (lat == st2_at) b1.fk_in = CHW'(fk + 1);
      b1.map_upd_p = (lat == upd_at);
      if (lat == upd_at) b1.chmap = upd_map;
      b1.abort_p = (lat == abort_at);
      @(negedge clk);
      if (b1.done_p) begin
        n1++;
        if (lat1 < 0) begin
          lat1 = lat;
          chk({tag, "_used_busy1"}, int'(b1.used_n), used_exp);
        end
      end
      if (b4.done_p) begin
        n4++;
        if (lat4 < 0) begin
          lat4 = lat;
          chk({tag, "_used_busy4"}, int'(b4.used_n), used_exp);
        end
      end
      if (abort_at > 0 && lat == abort_at + 1) begin
        chk({tag, "_abort_busy1"}, int'(b1.busy), 0);
        chk({tag, "_abort_busy4"}, int'(b4.busy), 0);
      end
      mx = (lat1 > lat4) ? lat1 : lat4;
      if (lat1 >= 0 && lat4 >= 0 && lat > mx + 3) break;
      if (abort_at > 0 && lat > abort_at + 40) break;
    end
    b1.start_p = 1'b0;
    b1.map_upd_p = 1'b0;
    b1.abort_p = 1'b0;
    if (abort_at > 0) begin
      chk({tag, "_ndone1"}, n1, 0);
      chk({tag, "_ndone4"}, n4, 0);
    end else begin
      chk({tag, "_lat1"}, lat1, el1);
      chk({tag, "_lat4"}, lat4, el4);
      chk({tag, "_ndone1"}, n1, 1);
      chk({tag, "_ndone4"}, n4, 1);
      h_fk = efk; h_rm = erm; h_err = eerr;
    end
    chk({tag, "_fk1"}, int'(b1.fk_out), h_fk);
    chk({tag, "_fk4"}, int'(b4.fk_out), h_fk);
    chk({tag, "_rm1"}, int'(b1.remapped), h_rm);
    chk({tag, "_rm4"}, int'(b4.remapped), h_rm);
    chk({tag, "_err1"}, int'(b1.err), h_err);
    chk({tag, "_err4"}, int'(b4.err), h_err);
    if (upd_at > 0) begin
      m_act = upd_map;
      chk({tag, "_used_after1"}, int'(b1.used_n), $countones(upd_map));
      chk({tag, "_used_after4"}, int'(b4.used_n), $countones(upd_map));
    end
  endtask

  initial begin
    bit [NCH-1:0] m1, m2, mr;
    int fk, idx, en;
    b1.start_p = 1'b0;
    b1.abort_p = 1'b0;
    b1.fk_in = '0;
    b1.remap_idx = '0;
    b1.afh_en = 1'b0;
    b1.chmap = '0;
    b1.map_upd_p = 1'b0;
    m_act = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 0, 0, 0, NCH);
    rstz = 1'b1;
    @(negedge clk);

    run_req("direct_all1", 40, 0, 1, 0, '0, 0, 0);

    m1 = '1;
    for (int i = 0; i < 20; i++) m1[i] = 1'b0;
    m2 = '1;
    for (int i = 0; i < 40; i++) m2[i] = 1'b0;
    load_map("map_m1", m1);
    run_req("remap23", 5, 3, 1, 0, '0, 0, 0);
    run_req("afh_off", 5, 0, 0, 0, '0, 0, 0);
    run_req("fk_range", 80, 0, 1, 0, '0, 0, 0);
    run_req("idx_range", 5, 59, 1, 0, '0, 0, 0);
    run_req("idx_last", 5, 58, 1, 0, '0, 0, 0);
    run_req("used_direct", 30, 7, 1, 0, '0, 0, 0);
    run_req("upd_in_scan", 5, 3, 1, 4, m2, 5, 0);
    run_req("abort_scan", 5, 20, 1, 0, '0, 0, 5);
    load_map("map_zero", '0);
    run_req("zero_map", 10, 0, 1, 0, '0, 0, 0);

    // Reset during a scan with a map update still pending.
    load_map("map_m1b", m1);
    b1.fk_in = CHW'(5);
    b1.remap_idx = CHW'(50);
    b1.afh_en = 1'b1;
    b1.start_p = 1'b1;
    @(posedge clk); #1;
    b1.start_p = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    b1.chmap = '0;
    b1.map_upd_p = 1'b1;
    @(posedge clk); #1;
    b1.map_upd_p = 1'b0;
    chk("pre_rst_busy1", int'(b1.busy), 1);
    #1 rstz = 1'b0;
    #1;
    check_idle_outputs("mid_rst", 0, 0, 0, NCH);
    @(negedge clk);
    rstz = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_pend_drop1", int'(b1.used_n), NCH);
    chk("rst_pend_drop4", int'(b4.used_n), NCH);
    m_act = '1;
    h_fk = 0; h_rm = 0; h_err = 0;

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        mr = '0;
        if ($urandom_range(0, 7) != 0)
          for (int i = 0; i < NCH; i++) mr[i] = ($urandom_range(0, 2) != 0);
        load_map("rnd_map", mr);
      end
      fk  = $urandom_range(0, 90);
      idx = $urandom_range(0, 80);
      en  = ($urandom_range(0, 4) != 0) ? 1 : 0;
      run_req("rnd", fk, idx, en, 0, '0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
